a8_bus_timer: RTL and testbench

- Front-end timing stage between the raw Atari 8-bit cartridge/PBI bus and the aperture decoders.
- Synchronises the asynchronous A8 phi2 clock into the 200 MHz `clk` domain and times each 558 ns bus cycle by counting `clk` cycles.
- Generates the `aValid` / `wValid` level qualifiers and the registered address, data and r/w values that every memory aperture consumes.

---
 rtl/a8_bus_timer.sv | 154 +++++++++++++++
 tb/tb_a8_bus_timer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a8_bus_timer.sv
// A8 phi2 bus-cycle timer: synchronises phi2/RST/RW, times each cycle, emits aValid/wValid/rdStrobe.
// Optional statistics counters (cycleCount, abortCount) enabled by defining A8_BUS_STATS_EN.
module a8_bus_timer #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_CYC    = 35,
   parameter int WRITE_CYC   = 85,
   parameter int READ_CYC    = 97,
   parameter int TIMEOUT_CYC = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a8_phi2,
   input  logic        a8_rst_n,
   input  logic        a8_rw_n,
   input  logic [15:0] a8_addr,
   input  logic [7:0]  a8_data,
   output logic        cycleStart,
   output logic        aValid,
   output logic        wValid,
   output logic        rdStrobe,
   output logic [15:0] busAddr,
   output logic [7:0]  busData,
   output logic        busRw_n,
   output logic        phi2Lost,
   output logic        shortCycle
`ifdef A8_BUS_STATS_EN
   ,
   output logic [31:0] cycleCount,
   output logic [15:0] abortCount
`endif
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] ADDR_C  = CW'(ADDR_CYC);
   localparam logic [CW-1:0] WRITE_C = CW'(WRITE_CYC);
   localparam logic [CW-1:0] READ_C  = CW'(READ_CYC);
   localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, ADDR_WAIT, ADDR_OK, DATA_OK} state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] phi2_sync, rstn_sync, rw_sync;
   logic                   phi2_prev;
   logic                   phi2_s, rstn_s, rw_s;
   logic                   fall;
   logic                   start, abort_short, latch_addr, latch_data, read_pt, timeout, drop;

   assign phi2_s = phi2_sync[SYNC_STAGES-1];
   assign rstn_s = rstn_sync[SYNC_STAGES-1];
   assign rw_s   = rw_sync[SYNC_STAGES-1];
   // No cycle may start while the A8 side is held in reset.
   assign fall   = phi2_prev & ~phi2_s & rstn_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         phi2_sync <= '0;
         rstn_sync <= '0;
         rw_sync   <= '1;
         phi2_prev <= 1'b0;
      end else begin
         phi2_sync <= {phi2_sync[SYNC_STAGES-2:0], a8_phi2};
         rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], a8_rst_n};
         rw_sync   <= {rw_sync[SYNC_STAGES-2:0], a8_rw_n};
         phi2_prev <= phi2_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (start)
            cnt <= CW'(1);
         else if (cnt != TO_C)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      if (!rstn_s)
         state_nxt = IDLE;
      else if (fall)
         state_nxt = ADDR_WAIT;
      else if (state != IDLE && cnt == TO_C)
         state_nxt = IDLE;
      else begin
         case (state)
            ADDR_WAIT: if (cnt == ADDR_C) state_nxt = ADDR_OK;
            ADDR_OK:   if ((cnt == WRITE_C && !busRw_n) || (cnt == READ_C && busRw_n))
                          state_nxt = DATA_OK;
            default:   state_nxt = state;
         endcase
      end
   end

   always_comb begin
      start       = fall;
      abort_short = fall && (state == ADDR_WAIT || state == ADDR_OK);
      latch_addr  = (state == ADDR_WAIT) && (state_nxt == ADDR_OK);
      latch_data  = (state == ADDR_OK) && (state_nxt == DATA_OK) && !busRw_n;
      read_pt     = (state == ADDR_OK) && (state_nxt == DATA_OK) && busRw_n;
      timeout     = rstn_s && !fall && (state != IDLE) && (cnt == TO_C);
      drop        = !rstn_s || start || timeout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycleStart <= 1'b0;
         shortCycle <= 1'b0;
         rdStrobe   <= 1'b0;
         aValid     <= 1'b0;
         wValid     <= 1'b0;
         busAddr    <= '0;
         busData    <= '0;
         busRw_n    <= 1'b1;
         phi2Lost   <= 1'b0;
      end else begin
         cycleStart <= start;
         shortCycle <= abort_short;
         rdStrobe   <= read_pt;
         if (drop)            aValid <= 1'b0;
         else if (latch_addr) aValid <= 1'b1;
         if (drop)            wValid <= 1'b0;
         else if (latch_data) wValid <= 1'b1;
         // Address and data buses are asynchronous; sampled only at their stable points.
         if (latch_addr) begin
            busAddr <= a8_addr;
            busRw_n <= rw_s;
         end
         if (latch_data) busData <= a8_data;
         if (start)        phi2Lost <= 1'b0;
         else if (timeout) phi2Lost <= 1'b1;
      end
   end

`ifdef A8_BUS_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycleCount <= '0;
         abortCount <= '0;
      end else begin
         if (latch_data || read_pt)
            cycleCount <= cycleCount + 32'd1;
         if ((abort_short || timeout) && abortCount != 16'hFFFF)
            abortCount <= abortCount + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_a8_bus_timer.sv
// Directed bench for a8_bus_timer: reset, write/read cycles, short cycle, timeout, A8 reset.
`timescale 1ns/100ps
module tb_a8_bus_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        a8_phi2, a8_rst_n, a8_rw_n;
   logic [15:0] a8_addr;
   logic [7:0]  a8_data;
   logic        cycleStart, aValid, wValid, rdStrobe, busRw_n, phi2Lost, shortCycle;
   logic [15:0] busAddr;
   logic [7:0]  busData;
`ifdef A8_BUS_STATS_EN
   logic [31:0] cycleCount;
   logic [15:0] abortCount;
`endif

   int checks   = 0;
   int failures = 0;

   // Per-cycle event record, offsets in clks relative to the cycleStart pulse
   int          tick = 0, st_tick = 0, start_cnt = 0, short_cnt = 0;
   int          av_off = -1, wv_off = -1, rd_off = -1, lost_off = -1, rd_cnt = 0;
   logic [15:0] av_addr = '0;
   logic [7:0]  wv_data = '0;
   logic        av_rw = 1'b0;
   logic [1:0]  vbefore = '0, vat = '0, lost_v = '0;
   logic        av_prev = 1'b0, wv_prev = 1'b0, lost_prev = 1'b0;

   always #2.5 clk = ~clk;

   a8_bus_timer dut (
      .clk        (clk),
      .rst        (rst),
      .a8_phi2    (a8_phi2),
      .a8_rst_n   (a8_rst_n),
      .a8_rw_n    (a8_rw_n),
      .a8_addr    (a8_addr),
      .a8_data    (a8_data),
      .cycleStart (cycleStart),
      .aValid     (aValid),
      .wValid     (wValid),
      .rdStrobe   (rdStrobe),
      .busAddr    (busAddr),
      .busData    (busData),
      .busRw_n    (busRw_n),
      .phi2Lost   (phi2Lost),
      .shortCycle (shortCycle)
`ifdef A8_BUS_STATS_EN
      ,
      .cycleCount (cycleCount),
      .abortCount (abortCount)
`endif
   );

   always @(negedge clk) begin
      tick++;
      if (cycleStart === 1'b1) begin
         start_cnt++;
         st_tick  = tick;
         av_off   = -1;
         wv_off   = -1;
         rd_off   = -1;
         lost_off = -1;
         rd_cnt   = 0;
         vbefore  = {av_prev, wv_prev};
         vat      = {aValid, wValid};
      end
      if (aValid === 1'b1 && av_prev !== 1'b1) begin
         av_off  = tick - st_tick;
         av_addr = busAddr;
         av_rw   = busRw_n;
      end
      if (wValid === 1'b1 && wv_prev !== 1'b1) begin
         wv_off  = tick - st_tick;
         wv_data = busData;
      end
      if (rdStrobe === 1'b1) begin
         rd_cnt++;
         rd_off = tick - st_tick;
      end
      if (shortCycle === 1'b1) short_cnt++;
      if (phi2Lost === 1'b1 && lost_prev !== 1'b1) begin
         lost_off = tick - st_tick;
         lost_v   = {aValid, wValid};
      end
      av_prev   = aValid;
      wv_prev   = wValid;
      lost_prev = phi2Lost;
   end

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic phi2_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                             input int lo, input int hi);
      a8_addr = a;
      a8_data = d;
      a8_rw_n = rw;
      a8_phi2 = 1'b0;
      #(lo);
      a8_phi2 = 1'b1;
      #(hi);
   endtask

   task automatic test_reset();
      rst = 1'b1; a8_phi2 = 1'b1; a8_rst_n = 1'b1; a8_rw_n = 1'b1;
      a8_addr = 16'h0000; a8_data = 8'h00;
      repeat (4) begin
         @(negedge clk);
         a8_phi2 = ~a8_phi2;
      end
      settle();
      checks++; if (cycleStart !== 1'b0) begin failures++; $display("FAIL rst_cycleStart got=%b exp=0", cycleStart); end
      checks++; if (aValid !== 1'b0) begin failures++; $display("FAIL rst_aValid got=%b exp=0", aValid); end
      checks++; if (wValid !== 1'b0) begin failures++; $display("FAIL rst_wValid got=%b exp=0", wValid); end
      checks++; if (rdStrobe !== 1'b0) begin failures++; $display("FAIL rst_rdStrobe got=%b exp=0", rdStrobe); end
      checks++; if (busAddr !== 16'h0000) begin failures++; $display("FAIL rst_busAddr got=%h exp=0000", busAddr); end
      checks++; if (busData !== 8'h00) begin failures++; $display("FAIL rst_busData got=%h exp=00", busData); end
      checks++; if (busRw_n !== 1'b1) begin failures++; $display("FAIL rst_busRw_n got=%b exp=1", busRw_n); end
      checks++; if (phi2Lost !== 1'b0) begin failures++; $display("FAIL rst_phi2Lost got=%b exp=0", phi2Lost); end
      checks++; if (shortCycle !== 1'b0) begin failures++; $display("FAIL rst_shortCycle got=%b exp=0", shortCycle); end
      a8_phi2 = 1'b1;
      rst = 1'b0;
      repeat (8) settle();
      checks++; if (start_cnt !== 0) begin failures++; $display("FAIL rst_no_start got=%0d exp=0", start_cnt); end
   endtask

   task automatic test_write();
      phi2_cycle(16'hD701, 8'h65, 1'b0, 279, 279);
      settle();
      checks++; if (av_off !== 35) begin failures++; $display("FAIL wr_aValid_offset got=%0d exp=35", av_off); end
      checks++; if (av_addr !== 16'hD701) begin failures++; $display("FAIL wr_busAddr got=%h exp=d701", av_addr); end
      checks++; if (av_rw !== 1'b0) begin failures++; $display("FAIL wr_busRw_n got=%b exp=0", av_rw); end
      checks++; if (wv_off !== 85) begin failures++; $display("FAIL wr_wValid_offset got=%0d exp=85", wv_off); end
      checks++; if (wv_data !== 8'h65) begin failures++; $display("FAIL wr_busData got=%h exp=65", wv_data); end
      checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL wr_no_rdStrobe got=%0d exp=0", rd_cnt); end
   endtask

   task automatic test_back_to_back_read();
      phi2_cycle(16'h0602, 8'h11, 1'b1, 279, 279);
      settle();
      checks++; if (vbefore !== 2'b11) begin failures++; $display("FAIL rd_valids_before_start got=%b exp=11", vbefore); end
      checks++; if (vat !== 2'b00) begin failures++; $display("FAIL rd_valids_drop_at_start got=%b exp=00", vat); end
      checks++; if (av_off !== 35) begin failures++; $display("FAIL rd_aValid_offset got=%0d exp=35", av_off); end
      checks++; if (av_addr !== 16'h0602) begin failures++; $display("FAIL rd_busAddr got=%h exp=0602", av_addr); end
      checks++; if (av_rw !== 1'b1) begin failures++; $display("FAIL rd_busRw_n got=%b exp=1", av_rw); end
      checks++; if (rd_off !== 97) begin failures++; $display("FAIL rd_strobe_offset got=%0d exp=97", rd_off); end
      checks++; if (rd_cnt !== 1) begin failures++; $display("FAIL rd_strobe_count got=%0d exp=1", rd_cnt); end
      checks++; if (wv_off !== -1) begin failures++; $display("FAIL rd_no_wValid got=%0d exp=-1", wv_off); end
      checks++; if (busData !== 8'h65) begin failures++; $display("FAIL rd_busData_held got=%h exp=65", busData); end
      checks++; if (short_cnt !== 0) begin failures++; $display("FAIL rd_no_short got=%0d exp=0", short_cnt); end
   endtask

   task automatic test_short_cycle();
      int s0;
      s0 = short_cnt;
      phi2_cycle(16'h1234, 8'hAA, 1'b0, 150, 150);
      settle();
      checks++; if (av_off !== 35) begin failures++; $display("FAIL sc_first_aValid got=%0d exp=35", av_off); end
      checks++; if (wv_off !== -1) begin failures++; $display("FAIL sc_first_no_wValid got=%0d exp=-1", wv_off); end
      phi2_cycle(16'h5678, 8'h5A, 1'b0, 279, 279);
      settle();
      checks++; if (short_cnt !== s0 + 1) begin failures++; $display("FAIL sc_short_pulses got=%0d exp=%0d", short_cnt, s0 + 1); end
      checks++; if (vbefore !== 2'b10) begin failures++; $display("FAIL sc_valids_before got=%b exp=10", vbefore); end
      checks++; if (vat !== 2'b00) begin failures++; $display("FAIL sc_valids_drop got=%b exp=00", vat); end
      checks++; if (av_addr !== 16'h5678) begin failures++; $display("FAIL sc_new_busAddr got=%h exp=5678", av_addr); end
      checks++; if (wv_off !== 85) begin failures++; $display("FAIL sc_new_wValid got=%0d exp=85", wv_off); end
      checks++; if (wv_data !== 8'h5A) begin failures++; $display("FAIL sc_new_busData got=%h exp=5a", wv_data); end
      checks++; if (busData !== 8'h5A) begin failures++; $display("FAIL sc_busData_port got=%h exp=5a", busData); end
   endtask

   task automatic test_timeout();
      int s0;
      s0 = short_cnt;
      phi2_cycle(16'hC000, 8'h3C, 1'b0, 279, 279);
      #400;
      settle();
      checks++; if (lost_off !== 160) begin failures++; $display("FAIL to_lost_offset got=%0d exp=160", lost_off); end
      checks++; if (lost_v !== 2'b00) begin failures++; $display("FAIL to_valids_at_lost got=%b exp=00", lost_v); end
      checks++; if (phi2Lost !== 1'b1) begin failures++; $display("FAIL to_phi2Lost_sticky got=%b exp=1", phi2Lost); end
      checks++; if (short_cnt !== s0) begin failures++; $display("FAIL to_no_short got=%0d exp=%0d", short_cnt, s0); end
      phi2_cycle(16'h0700, 8'h00, 1'b1, 279, 279);
      settle();
      checks++; if (phi2Lost !== 1'b0) begin failures++; $display("FAIL to_phi2Lost_clear got=%b exp=0", phi2Lost); end
      checks++; if (vbefore !== 2'b00) begin failures++; $display("FAIL to_idle_before_start got=%b exp=00", vbefore); end
      checks++; if (av_off !== 35) begin failures++; $display("FAIL to_next_aValid got=%0d exp=35", av_off); end
      checks++; if (rd_off !== 97) begin failures++; $display("FAIL to_next_rdStrobe got=%0d exp=97", rd_off); end
   endtask

   task automatic test_a8_reset();
      int st0, sh0;
      a8_addr = 16'hD500; a8_data = 8'h77; a8_rw_n = 1'b0;
      a8_phi2 = 1'b0;
      #300;
      settle();
      checks++; if (aValid !== 1'b1) begin failures++; $display("FAIL ar_aValid_before got=%b exp=1", aValid); end
      sh0 = short_cnt;
      a8_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (aValid !== 1'b0) begin failures++; $display("FAIL ar_aValid_drop got=%b exp=0", aValid); end
      checks++; if (wValid !== 1'b0) begin failures++; $display("FAIL ar_wValid_drop got=%b exp=0", wValid); end
      a8_phi2 = 1'b1;
      #279;
      st0 = start_cnt;
      phi2_cycle(16'h1111, 8'h22, 1'b0, 279, 279);
      phi2_cycle(16'h3333, 8'h44, 1'b1, 279, 279);
      settle();
      checks++; if (start_cnt !== st0) begin failures++; $display("FAIL ar_no_cycles got=%0d exp=%0d", start_cnt, st0); end
      checks++; if (short_cnt !== sh0) begin failures++; $display("FAIL ar_no_short got=%0d exp=%0d", short_cnt, sh0); end
      checks++; if (aValid !== 1'b0) begin failures++; $display("FAIL ar_aValid_low got=%b exp=0", aValid); end
      a8_rst_n = 1'b1;
      #100;
      phi2_cycle(16'hBEEF, 8'h99, 1'b0, 279, 279);
      settle();
      checks++; if (av_off !== 35) begin failures++; $display("FAIL ar_resume_aValid got=%0d exp=35", av_off); end
      checks++; if (av_addr !== 16'hBEEF) begin failures++; $display("FAIL ar_resume_busAddr got=%h exp=beef", av_addr); end
      checks++; if (wv_data !== 8'h99) begin failures++; $display("FAIL ar_resume_busData got=%h exp=99", wv_data); end
   endtask

`ifdef A8_BUS_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      settle();
      checks++; if (cycleCount !== 32'd0) begin failures++; $display("FAIL st_cycleCount_rst got=%0d exp=0", cycleCount); end
      checks++; if (abortCount !== 16'd0) begin failures++; $display("FAIL st_abortCount_rst got=%0d exp=0", abortCount); end
      #50;
      for (int i = 0; i < 10; i++)
         phi2_cycle(16'h0600 + 16'(i), 8'(i), 1'b1, 279, 279);
      phi2_cycle(16'h0610, 8'h10, 1'b0, 150, 150);
      a8_phi2 = 1'b0;
      #100;
      settle();
      checks++; if (cycleCount !== 32'd10) begin failures++; $display("FAIL st_cycleCount got=%0d exp=10", cycleCount); end
      checks++; if (abortCount !== 16'd1) begin failures++; $display("FAIL st_abortCount got=%0d exp=1", abortCount); end
      a8_phi2 = 1'b1;
      #279;
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_back_to_back_read();
      test_short_cycle();
      test_timeout();
      test_a8_reset();
`ifdef A8_BUS_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
